// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus: the upstream lane drives the control and data bits.
// Detection status flows back to the lane on the same interface.
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             in_valid;
  logic             in;
  logic             match;
  logic [CNT_W-1:0] out;
  logic             sat;
  logic             busy;

  modport master (
    output load, pattern, overlap, in_valid, in,
    input  match, out, sat, busy
  );

  modport slave (
    input  load, pattern, overlap, in_valid, in,
    output match, out, sat, busy
  );
endinterface

// File: rtl/seq_detect_param.sv
// MSB-first serial pattern detector with a loadable pattern and an overlap/non-overlap mode.
// It also keeps a saturating match counter. All outputs are registered.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              reset,
  seq_detect_param_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t            state;
  logic [PAT_W-1:0]  pattern_reg;
  logic              mode_reg;
  logic [PAT_W-1:0]  history;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  cnt;
  logic              match_r;
  logic              sat_r;
  logic              busy_r;

  logic              accept;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              hit;
  logic [CNT_W-1:0]  cnt_inc;

  // A load in the same cycle takes priority, so that bit is dropped.
  always_comb begin
    accept   = bus.in_valid && !bus.load && (state != IDLE);
    hist_nxt = {history[PAT_W-2:0], bus.in};
    fill_nxt = (fill == FILL_FULL) ? fill : fill + 1'b1;
    hit      = accept && (fill_nxt == FILL_FULL) && (hist_nxt == pattern_reg);
    cnt_inc  = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pattern_reg <= '0;
      mode_reg    <= 1'b0;
      history     <= '0;
      fill        <= '0;
      cnt         <= '0;
      match_r     <= 1'b0;
      sat_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      match_r <= 1'b0;
      if (bus.load) begin
        pattern_reg <= bus.pattern;
        mode_reg    <= bus.overlap;
        history     <= '0;
        fill        <= '0;
        cnt         <= '0;
        sat_r       <= 1'b0;
        busy_r      <= 1'b1;
        state       <= RUN;
      end else if (accept) begin
        history <= hist_nxt;
        // Non-overlap mode masks the stale history by emptying the fill count.
        fill    <= (hit && !mode_reg) ? '0 : fill_nxt;
        match_r <= hit;
        if (hit && state == RUN) begin
          cnt <= cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state <= SAT;
            sat_r <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.match = match_r;
  assign bus.out   = cnt;
  assign bus.sat   = sat_r;
  assign bus.busy  = busy_r;

endmodule
